pattern_detector_param: RTL and testbench

//  Parametrised serial pattern detector: successor to the fixed 2-bit dual detector. Matches a
//  run-time programmable pattern of 1..MAX_LEN bits on a serial stream. Overlapping and
//  non-overlapping modes. Registered Moore-style match pulse and saturating match counter.

---
 rtl/pattern_detector_param.sv | 115 +++++++++++
 tb/tb_pattern_detector_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_detector_param
//  Description : Parametrised serial pattern detector. Matches a run-time
//                programmable pattern of 1..MAX_LEN bits on a serial stream,
//                with overlapping or restart-after-match operation. Produces
//                a registered one-cycle match pulse and a saturating counter.
//  Ports       : clk          rising-edge clock
//                reset        asynchronous active-high reset
//                clear        synchronous clear of history, z, match_count
//                en           sample strobe, w consumed only when en=1
//                w            serial input bit
//                pattern      target, pattern[pat_len-1] is the oldest bit
//                pat_len      active pattern length (0 disables detection)
//                overlap      1 = overlapping matches, 0 = restart after match
//                z            one-cycle registered match pulse
//                match_count  saturating match counter
//                armed        history holds a full pattern length of bits
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    input  logic               w,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;

    logic [LEN_W-1:0]   w_len;
    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W:0]     w_fill_inc;
    logic               w_full;
    logic               w_match;
    logic               w_restart;
    logic [LEN_W-1:0]   w_fill_next;

    // Lengths above MAX_LEN are clamped; zero leaves detection disabled.
    assign w_len = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;

    // Only the low w_len history bits take part in the comparison.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(w_len)) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign w_hist_next = {r_hist[MAX_LEN-2:0], w};
    // Extra bit keeps fill+1 from wrapping when fill is already at its top.
    assign w_fill_inc  = {1'b0, r_fill} + (LEN_W+1)'(1);
    assign w_full      = (w_fill_inc >= {1'b0, w_len});

    assign w_match = en && (w_len != '0) && w_full
                     && (((w_hist_next ^ pattern) & w_mask) == '0);

    // Non-overlapping mode discards the history once it has been matched.
    assign w_restart   = w_match && !overlap;
    assign w_fill_next = w_restart ? '0 :
                         w_full    ? w_len : w_fill_inc[LEN_W-1:0];

    assign w_state_next = (!w_restart && (w_fill_next == w_len)) ? ARMED : FILL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist      <= '0;
            r_fill      <= '0;
            r_state     <= FILL;
            z           <= 1'b0;
            match_count <= '0;
        end else if (clear) begin
            r_hist      <= '0;
            r_fill      <= '0;
            r_state     <= FILL;
            z           <= 1'b0;
            match_count <= '0;
        end else if (en) begin
            r_hist  <= w_hist_next;
            r_fill  <= w_fill_next;
            r_state <= w_state_next;
            z       <= w_match;
            if (w_match && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end else begin
            z <= 1'b0;
        end
    end

    assign armed = (r_state == ARMED);

endmodule
`default_nettype wire

// File: tb/tb_pattern_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_detector_param
//  Description : Self-checking bench for pattern_detector_param. Two
//                instances share all inputs: one with an 8-bit counter and
//                one with a 2-bit counter to exercise saturation. A bit-queue
//                reference model produces expected outputs into a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_detector_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       en;
    logic       w;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       overlap;

    logic       z1, armed1, z2, armed2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    pattern_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .w(w),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .z(z1), .match_count(cnt1), .armed(armed1)
    );

    pattern_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .w(w),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .z(z2), .match_count(cnt2), .armed(armed2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic z;
        int   cnt;
        logic armed;
    } exp_t;

    exp_t sb[$];
    bit   mbits[$];     // sampled bits since last clear, newest at the back
    int   mfill  = 0;   // bits counted toward the next match
    int   mcnt   = 0;   // unbounded match count
    logic mz     = 1'b0;
    logic marmed = 1'b0;

    task automatic model_reset();
        mbits.delete();
        mfill  = 0;
        mcnt   = 0;
        mz     = 1'b0;
        marmed = 1'b0;
    endtask

    task automatic model_step();
        int L;
        int valid;
        bit hit;
        if (reset || clear) begin
            model_reset();
        end else if (!en) begin
            mz = 1'b0;
        end else begin
            L = (pat_len > 8) ? 8 : int'(pat_len);
            mbits.push_back(w);
            if (mbits.size() > 8) void'(mbits.pop_front());
            valid = mfill + 1;
            hit = (L > 0) && (valid >= L) && (mbits.size() >= L);
            if (hit) begin
                for (int k = 0; k < L; k++) begin
                    if (mbits[mbits.size()-1-k] != pattern[k]) hit = 0;
                end
            end
            if (hit && !overlap) begin
                mfill  = 0;
                marmed = 1'b0;
            end else begin
                mfill  = (valid > L) ? L : valid;
                marmed = (mfill == L);
            end
            mz = hit;
            if (hit) mcnt++;
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Drive one clock of stimulus, push the model's prediction, compare after the edge.
    task automatic cycle(input logic e, input logic b, input logic c);
        exp_t x;
        en    = e;
        w     = b;
        clear = c;
        model_step();
        sb.push_back('{mz, mcnt, marmed});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("z",        {31'd0, z1},     {31'd0, x.z});
        check("count",    {24'd0, cnt1},   sat(x.cnt, 255));
        check("armed",    {31'd0, armed1}, {31'd0, x.armed});
        check("z_w2",     {31'd0, z2},     {31'd0, x.z});
        check("count_w2", {30'd0, cnt2},   sat(x.cnt, 3));
        check("armed_w2", {31'd0, armed2}, {31'd0, x.armed});
    endtask

    // Send the low n bits of 'bits', MSB first, with up to gap_max idle cycles between.
    task automatic send(input logic [31:0] bits, input int n, input int gap_max);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) begin
            cycle(1'b1, v[i], 1'b0);
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 1)) cycle(1'b0, 1'($urandom_range(1, 0)), 1'b0);
            end
        end
    endtask

    int exp_sat [6];

    initial begin
        exp_sat = '{1, 2, 3, 3, 3, 3};
        reset   = 1'b1;
        clear   = 1'b0;
        en      = 1'b0;
        w       = 1'b0;
        pattern = 8'b0000_1011;
        pat_len = 4'd4;
        overlap = 1'b1;

        // Reset held while en toggles and bits stream in.
        #1;
        check("reset_z",     {31'd0, z1},     0);
        check("reset_count", {24'd0, cnt1},   0);
        check("reset_armed", {31'd0, armed1}, 0);
        for (int i = 0; i < 6; i++) cycle(1'(i % 2), 1'($urandom_range(1, 0)), 1'b0);
        reset = 1'b0;
        send(32'b101, 3, 0);
        check("fill_not_armed", {31'd0, armed1}, 0);

        // Overlapping matches.
        cycle(1'b0, 1'b0, 1'b1);
        send(32'b1011011, 7, 0);
        check("overlap_total", {24'd0, cnt1}, 2);

        // Non-overlapping: second match would need fresh bits.
        overlap = 1'b0;
        cycle(1'b0, 1'b0, 1'b1);
        send(32'b1011011, 7, 0);
        check("nonoverlap_total", {24'd0, cnt1}, 1);

        // Idle gaps between samples.
        overlap = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        send(32'b1011011, 7, 3);
        check("gaps_total", {24'd0, cnt1}, 2);

        // Saturation with a single-bit pattern.
        pattern = 8'b0000_0001;
        pat_len = 4'd1;
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check("saturate_w2", {30'd0, cnt2}, exp_sat[i]);
        end

        // Zero length disables detection.
        pat_len = 4'd0;
        cycle(1'b0, 1'b0, 1'b1);
        send(32'hFF00_FFFF, 32, 0);
        check("len0_total", {24'd0, cnt1}, 0);

        // Over-long length clamps to eight bits.
        pat_len = 4'd15;
        pattern = 8'hB2;
        cycle(1'b0, 1'b0, 1'b1);
        send(32'hB2, 8, 0);
        check("len15_total", {24'd0, cnt1}, 1);

        // Clear on the completing edge wins.
        pattern = 8'b0000_1011;
        pat_len = 4'd4;
        cycle(1'b0, 1'b0, 1'b1);
        send(32'b101, 3, 0);
        cycle(1'b1, 1'b1, 1'b1);
        check("clear_z",     {31'd0, z1},     0);
        check("clear_armed", {31'd0, armed1}, 0);

        // Asynchronous reset mid-cycle.
        send(32'b1011, 4, 0);
        check("pre_reset_count", {24'd0, cnt1}, 1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_z",     {31'd0, z1},     0);
        check("async_count", {24'd0, cnt1},   0);
        check("async_armed", {31'd0, armed1}, 0);
        cycle(1'b1, 1'b1, 1'b0);
        reset = 1'b0;

        // Randomised traffic with occasional reconfiguration.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(40, 0) == 0) begin
                overlap = 1'($urandom_range(1, 0));
                pat_len = 4'($urandom_range(15, 0));
                pattern = 8'($urandom_range(255, 0));
                cycle(1'b0, 1'b0, 1'b1);
            end else begin
                cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
